// File: rtl/efi_pkg.sv
// Shared EFI front-end types: tooth-FSM states, default widths and limits.
// Used by the VR edge qualifier and its glitch filter.
package efi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_RUN
    } vr_state_e;

    localparam int unsigned PERIOD_W_DEF     = 32;
    localparam logic [31:0] STALL_CYCLES_DEF = 32'd4_000_000;

    function automatic logic [7:0] filt_thresh(input logic [7:0] cfg);
        return (cfg == 8'd0) ? 8'd1 : cfg;
    endfunction

endpackage

// File: rtl/vr_edge_qualifier_if.sv
// Bundle of the VR conditioner pin, filter config and qualified outputs.
// master = consumer/driver side, slave = the qualifier itself.
interface vr_edge_qualifier_if #(
    parameter int PERIOD_W = 32
);
    logic                vrin;
    logic [7:0]          cfg_filter_cycles;
    logic                vr_clean;
    logic                tooth_edge;
    logic [PERIOD_W-1:0] tooth_period;
    logic                period_valid;
    logic                stalled;
    logic [15:0]         reject_cnt;

    modport master (
        output vrin, cfg_filter_cycles,
        input  vr_clean, tooth_edge, tooth_period,
        input  period_valid, stalled, reject_cnt
    );

    modport slave (
        input  vrin, cfg_filter_cycles,
        output vr_clean, tooth_edge, tooth_period,
        output period_valid, stalled, reject_cnt
    );
endinterface

// File: rtl/vr_glitch_filter.sv
// Synchronizes the raw VR pin and applies a stable-sample level filter.
// rise is combinational: high in the cycle before vr_clean goes 0->1.
module vr_glitch_filter
    import efi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vrin,
    input  logic [7:0] cfg_filter_cycles,
    output logic       vr_clean,
    output logic       rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             fcnt_q, fcnt_d;
    logic                   clean_q, clean_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], vrin};
        fcnt_d  = 8'd0;
        clean_d = clean_q;
        if (synced != clean_q) begin
            // >= so that lowering cfg mid-count still toggles promptly
            if ({1'b0, fcnt_q} + 9'd1 >= {1'b0, filt_thresh(cfg_filter_cycles)}) begin
                clean_d = ~clean_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fcnt_q  <= 8'd0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fcnt_q  <= fcnt_d;
            clean_q <= clean_d;
        end
    end

    assign vr_clean = clean_q;
    assign rise     = clean_d & ~clean_q;

endmodule

// File: rtl/vr_edge_qualifier.sv
// VR crank edge qualifier: filter, blanking, period measure, stall detect.
// Optional blanked-edge counter enabled by VR_EDGE_REJECT_CNT_EN.
module vr_edge_qualifier
    import efi_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter int          PERIOD_W     = PERIOD_W_DEF,
    parameter int          BLANK_SHIFT  = 2,
    parameter logic [31:0] STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    vr_edge_qualifier_if.slave  vif
);

    localparam logic [PERIOD_W-1:0] STALL_P = PERIOD_W'(STALL_CYCLES);

    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                rst_n;
    vr_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                edge_q, edge_d;
    logic                pvalid_q, pvalid_d;
    logic                stalled_q, stalled_d;
    logic [PERIOD_W-1:0] pcnt_inc, pcnt_p1;
    logic                rise, blank_ok, stall_hit, accept;

    // Release of the internal reset is retimed so every flop leaves reset together
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    vr_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filt (
        .clk               (clk),
        .rst_n             (rst_n),
        .vrin              (vif.vrin),
        .cfg_filter_cycles (vif.cfg_filter_cycles),
        .vr_clean          (vif.vr_clean),
        .rise              (rise)
    );

    assign pcnt_p1   = pcnt_q + 1'b1;
    assign pcnt_inc  = (pcnt_q >= STALL_P) ? STALL_P : pcnt_p1;
    assign blank_ok  = pcnt_p1 >= (period_q >> BLANK_SHIFT);
    assign stall_hit = (state_q != ST_IDLE) && (pcnt_inc == STALL_P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Stall has priority: a candidate arriving with it is dropped
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (stall_hit) begin
            state_d = ST_IDLE;
        end else if (rise) begin
            unique case (state_q)
                ST_IDLE: begin
                    accept  = 1'b1;
                    state_d = ST_FIRST;
                end
                ST_FIRST: begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN:  accept  = blank_ok;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pcnt_d    = pcnt_inc;
        edge_d    = 1'b0;
        period_d  = period_q;
        pvalid_d  = pvalid_q;
        stalled_d = stalled_q;
        unique case (1'b1)
            stall_hit: begin
                stalled_d = 1'b1;
                pvalid_d  = 1'b0;
            end
            accept: begin
                pcnt_d    = '0;
                edge_d    = 1'b1;
                stalled_d = 1'b0;
                if (state_q != ST_IDLE) begin
                    period_d = pcnt_p1;
                    pvalid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q    <= '0;
            edge_q    <= 1'b0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
            stalled_q <= 1'b1;
        end else begin
            pcnt_q    <= pcnt_d;
            edge_q    <= edge_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
            stalled_q <= stalled_d;
        end
    end

    assign vif.tooth_edge   = edge_q;
    assign vif.tooth_period = period_q;
    assign vif.period_valid = pvalid_q;
    assign vif.stalled      = stalled_q;

`ifdef VR_EDGE_REJECT_CNT_EN
    logic [15:0] rej_q, rej_d;
    logic        reject;

    assign reject = rise && !stall_hit && (state_q == ST_RUN) && !blank_ok;

    always_comb begin
        rej_d = rej_q;
        if (reject && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rej_q <= 16'd0;
        else        rej_q <= rej_d;
    end

    assign vif.reject_cnt = rej_q;
`else
    assign vif.reject_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vr_edge_qualifier.sv
// Self-checking bench for vr_edge_qualifier (STALL_CYCLES shortened to 5000).
// Accepted edges are scoreboarded; filter/stall timing is checked inline.
module tb_vr_edge_qualifier;
    import efi_pkg::*;

    typedef struct {
        logic [31:0] period;
        logic        valid;
    } edge_t;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    edge_t exp_q[$];
    edge_t obs_q[$];

    vr_edge_qualifier_if #(.PERIOD_W(32)) vif();

    vr_edge_qualifier #(
        .SYNC_STAGES  (2),
        .PERIOD_W     (32),
        .BLANK_SHIFT  (2),
        .STALL_CYCLES (32'd5000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vif     (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (vif.tooth_edge === 1'b1)
            obs_q.push_back('{vif.tooth_period, vif.period_valid});
    end

    task automatic hold(input logic v, input int n);
        vif.vrin = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        vif.vrin = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        vif.cfg_filter_cycles = 8'd4;
        do_reset();
        repeat (20) @(negedge clk);
        vectors++;
        if (vif.vr_clean !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_vr_clean: got %b want 0", vif.vr_clean);
        end
        vectors++;
        if (vif.tooth_edge !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_tooth_edge: got %b want 0", vif.tooth_edge);
        end
        vectors++;
        if (vif.tooth_period !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_period: got %0d want 0", vif.tooth_period);
        end
        vectors++;
        if (vif.period_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pvalid: got %b want 0", vif.period_valid);
        end
        vectors++;
        if (vif.stalled !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_stalled: got %b want 1", vif.stalled);
        end
        vectors++;
        if (vif.reject_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_reject: got %0d want 0", vif.reject_cnt);
        end
        repeat (6000) @(negedge clk);
        vectors++;
        if (vif.stalled !== 1'b1 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL idle_hold: stalled %b edges %0d want 1/0", vif.stalled, obs_q.size());
        end
    endtask

    task automatic test_filter();
        bit saw;
        vif.cfg_filter_cycles = 8'd4;
        do_reset();
        hold(1'b1, 3);
        vif.vrin = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (vif.vr_clean !== 1'b0 || vif.tooth_edge !== 1'b0) saw = 1'b1;
        end
        vectors++;
        if (saw) begin
            miscompares++;
            $display("FAIL glitch3: got level/edge change want none");
        end
        hold(1'b1, 4);
        vif.vrin = 1'b0;
        @(negedge clk);
        vectors++;
        if (vif.vr_clean !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse4_early: got %b want 0", vif.vr_clean);
        end
        @(negedge clk);
        vectors++;
        if (vif.vr_clean !== 1'b1 || vif.tooth_edge !== 1'b1) begin
            miscompares++;
            $display("FAIL pulse4_rise: got clean %b edge %b want 1/1",
                     vif.vr_clean, vif.tooth_edge);
        end
        hold(1'b0, 20);
        vif.cfg_filter_cycles = 8'd0;
        hold(1'b1, 1);
        vif.vrin = 1'b0;
        @(negedge clk);
        vectors++;
        if (vif.vr_clean !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg0_early: got %b want 0", vif.vr_clean);
        end
        @(negedge clk);
        vectors++;
        if (vif.vr_clean !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg0_rise: got %b want 1", vif.vr_clean);
        end
        hold(1'b0, 10);
        vif.cfg_filter_cycles = 8'd4;
    endtask

    task automatic test_square();
        edge_t e, o;
        vif.cfg_filter_cycles = 8'd4;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{(i == 0) ? 32'd0 : 32'd1000, (i != 0)});
            hold(1'b1, 500);
            hold(1'b0, 500);
        end
        hold(1'b0, 20);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL sq_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.period !== e.period || o.valid !== e.valid) begin
                miscompares++;
                $display("FAIL sq_edge: got %0d/%b want %0d/%b",
                         o.period, o.valid, e.period, e.valid);
            end
        end
        vectors++;
        if (vif.stalled !== 1'b0 || vif.tooth_period !== 32'd1000) begin
            miscompares++;
            $display("FAIL sq_steady: got stalled %b period %0d want 0/1000",
                     vif.stalled, vif.tooth_period);
        end
    endtask

    task automatic test_blanking();
        edge_t e, o;
        logic [15:0] exp_rej;
`ifdef VR_EDGE_REJECT_CNT_EN
        exp_rej = 16'd1;
`else
        exp_rej = 16'd0;
`endif
        vif.cfg_filter_cycles = 8'd4;
        do_reset();
        exp_q.push_back('{32'd0, 1'b0});
        hold(1'b1, 500);
        hold(1'b0, 500);
        exp_q.push_back('{32'd1000, 1'b1});
        hold(1'b1, 100);
        hold(1'b0, 100);
        hold(1'b1, 30);
        hold(1'b0, 30);
        exp_q.push_back('{32'd260, 1'b1});
        hold(1'b1, 100);
        hold(1'b0, 100);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL blank_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.period !== e.period || o.valid !== e.valid) begin
                miscompares++;
                $display("FAIL blank_edge: got %0d/%b want %0d/%b",
                         o.period, o.valid, e.period, e.valid);
            end
        end
        vectors++;
        if (vif.reject_cnt !== exp_rej) begin
            miscompares++;
            $display("FAIL reject_cnt: got %0d want %0d", vif.reject_cnt, exp_rej);
        end
        vectors++;
        if (vif.tooth_period !== 32'd260) begin
            miscompares++;
            $display("FAIL blank_period: got %0d want 260", vif.tooth_period);
        end
    endtask

    task automatic test_stall();
        edge_t e, o;
        bit got;
        int n;
        vif.cfg_filter_cycles = 8'd4;
        do_reset();
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'd1000, 1'b1});
        exp_q.push_back('{32'd1000, 1'b0});
        hold(1'b1, 500);
        hold(1'b0, 500);
        vif.vrin = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (vif.tooth_edge === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL stall_edge_wait: got timeout want edge within 50");
        end
        for (int j = 1; j <= 5000; j++) begin
            if (j == 300) vif.vrin = 1'b0;
            @(negedge clk);
            if (j == 4999) begin
                vectors++;
                if (vif.stalled !== 1'b0 || vif.period_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_early: got %b/%b want 0/1",
                             vif.stalled, vif.period_valid);
                end
            end
            if (j == 5000) begin
                vectors++;
                if (vif.stalled !== 1'b1 || vif.period_valid !== 1'b0 ||
                    vif.tooth_period !== 32'd1000) begin
                    miscompares++;
                    $display("FAIL stall_hit: got %b/%b/%0d want 1/0/1000",
                             vif.stalled, vif.period_valid, vif.tooth_period);
                end
            end
        end
        hold(1'b1, 50);
        hold(1'b0, 20);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.period !== e.period || o.valid !== e.valid) begin
                miscompares++;
                $display("FAIL stall_edge: got %0d/%b want %0d/%b",
                         o.period, o.valid, e.period, e.valid);
            end
        end
        vectors++;
        if (vif.stalled !== 1'b0) begin
            miscompares++;
            $display("FAIL reacquire: got stalled %b want 0", vif.stalled);
        end
    endtask

    initial begin
        vectors               = 0;
        miscompares           = 0;
        reset_n               = 1'b0;
        vif.vrin              = 1'b0;
        vif.cfg_filter_cycles = 8'd4;
        test_reset();
        test_filter();
        test_square();
        test_blanking();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
